// File: rtl/instr_mem_loader.sv
// Streams 32-bit program words into a byte-wide instruction RAM, little-endian, 4 writes per word.
// Optional INSTR_MEM_LOADER_CHECKSUM_EN adds a running word checksum and expected_sum compare.
module instr_mem_loader #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned CNT_W     = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [7:0]       mem_wdata,
  output logic             busy,
  output logic             done,
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
  output logic [31:0]      checksum,
  input  logic [31:0]      expected_sum,
`endif
  output logic             error
);

  typedef enum logic [1:0] {StIdle, StWaitWord, StWrite, StDone} state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [7:0]       mem_wdata_q, mem_wdata_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [31:0]      word_q, word_d;
  logic [1:0]       idx_q, idx_d;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
  logic [31:0]      checksum_q, checksum_d;
  logic [31:0]      exp_sum_q, exp_sum_d;
`endif

  logic [33:0] end_addr;
  logic [1:0]  idx_nxt;
  logic [7:0]  byte_nxt;

  // 34-bit sum so a huge base_addr cannot wrap past the bounds check
  assign end_addr = {2'b00, base_addr} + {{(32 - CNT_W){1'b0}}, word_count, 2'b00};
  assign idx_nxt  = idx_q + 2'd1;

  always_comb begin
    byte_nxt = word_q[7:0];
    unique case (idx_nxt)
      2'd0: byte_nxt = word_q[7:0];
      2'd1: byte_nxt = word_q[15:8];
      2'd2: byte_nxt = word_q[23:16];
      2'd3: byte_nxt = word_q[31:24];
      default: byte_nxt = word_q[7:0];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    word_d      = word_q;
    idx_d       = idx_q;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    checksum_d  = checksum_q;
    exp_sum_d   = exp_sum_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (base_addr[1:0] != 2'b00 || end_addr > 34'(MEM_BYTES)) begin
            error_d = 1'b1;
          end else if (word_count == '0) begin
            done_d  = 1'b1;
            error_d = 1'b0;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
            checksum_d = '0;
            exp_sum_d  = expected_sum;
            error_d    = (expected_sum != 32'd0);
`endif
          end else begin
            addr_d      = base_addr;
            remaining_d = word_count;
            error_d     = 1'b0;
            busy_d      = 1'b1;
            in_ready_d  = 1'b1;
            state_d     = StWaitWord;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
            checksum_d = '0;
            exp_sum_d  = expected_sum;
`endif
          end
        end
      end
      StWaitWord: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          in_ready_d  = 1'b0;
          word_d      = in_data;
          idx_d       = 2'd0;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = in_data[7:0];
          state_d     = StWrite;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
          checksum_d = checksum_q + in_data;
`endif
        end
      end
      StWrite: begin
        if (idx_q != 2'd3) begin
          idx_d       = idx_nxt;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q + {30'd0, idx_nxt};
          mem_wdata_d = byte_nxt;
        end else begin
          addr_d      = addr_q + 32'd4;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == CNT_W'(1)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StDone;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
            if (checksum_q != exp_sum_q) error_d = 1'b1;
`endif
          end else begin
            in_ready_d = 1'b1;
            state_d    = StWaitWord;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      addr_q      <= '0;
      remaining_q <= '0;
      word_q      <= '0;
      idx_q       <= '0;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
      checksum_q  <= '0;
      exp_sum_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
      checksum_q  <= checksum_d;
      exp_sum_q   <= exp_sum_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
  assign checksum  = checksum_q;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader; outputs are sampled 1ns after each rising edge.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [8:0]  word_count = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, mem_we, busy, done, error;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
  logic [31:0] expected_sum = '0;
`endif

  int checks = 0;
  int failures = 0;

  instr_mem_loader #(.MEM_BYTES(1024), .CNT_W(9)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    .checksum   (checksum),
    .expected_sum(expected_sum),
`endif
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called in the handshake cycle; checks the four byte writes that follow.
  task automatic write_seq(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      step();
      check("we", {31'd0, mem_we}, 32'd1);
      check("addr", mem_addr, a + 32'(k));
      check("wdata", {24'd0, mem_wdata}, {24'd0, w[8*k +: 8]});
      check("rdy_low", {31'd0, in_ready}, 32'd0);
    end
  endtask

  task automatic kick(input logic [31:0] b, input logic [8:0] n);
    start = 1'b1; base_addr = b; word_count = n;
    step();
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    step(); step();
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    rst = 1'b0;
    step();

    // Basic load, in_valid always high
    in_valid = 1'b1; in_data = 32'h0050_0093;
    kick(32'h0, 9'd2);
    check("b_ready", {31'd0, in_ready}, 32'd1);
    check("b_busy", {31'd0, busy}, 32'd1);
    write_seq(32'h0, 32'h0050_0093);
    in_data = 32'h0010_0113;
    step();
    check("b_ready2", {31'd0, in_ready}, 32'd1);
    check("b_we_gap", {31'd0, mem_we}, 32'd0);
    write_seq(32'h4, 32'h0010_0113);
    in_valid = 1'b0;
    step();
    check("b_done", {31'd0, done}, 32'd1);
    check("b_busy_end", {31'd0, busy}, 32'd0);
    check("b_we_end", {31'd0, mem_we}, 32'd0);
    step();
    check("b_done_once", {31'd0, done}, 32'd0);

    // Backpressure: 3 idle cycles between words
    kick(32'h10, 9'd2);
    check("bp_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_data = 32'hA1B2_C3D4;
    write_seq(32'h10, 32'hA1B2_C3D4);
    in_valid = 1'b0;
    step();
    repeat (3) begin
      check("bp_wait_ready", {31'd0, in_ready}, 32'd1);
      check("bp_wait_we", {31'd0, mem_we}, 32'd0);
      check("bp_wait_done", {31'd0, done}, 32'd0);
      step();
    end
    in_valid = 1'b1; in_data = 32'h1122_3344;
    write_seq(32'h14, 32'h1122_3344);
    in_valid = 1'b0;
    step();
    check("bp_done", {31'd0, done}, 32'd1);
    step();

    // Start rejects
    kick(32'h2, 9'd1);
    check("rj_mis_err", {31'd0, error}, 32'd1);
    check("rj_mis_busy", {31'd0, busy}, 32'd0);
    check("rj_mis_rdy", {31'd0, in_ready}, 32'd0);
    step();
    check("rj_mis_we", {31'd0, mem_we}, 32'd0);
    kick(32'h3FC, 9'd2);
    check("rj_oob_err", {31'd0, error}, 32'd1);
    check("rj_oob_busy", {31'd0, busy}, 32'd0);
    step();
    check("rj_oob_we", {31'd0, mem_we}, 32'd0);
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    kick(32'h3FC, 9'd1);
    check("rj_ok_err", {31'd0, error}, 32'd0);
    check("rj_ok_busy", {31'd0, busy}, 32'd1);
    write_seq(32'h3FC, 32'hDEAD_BEEF);
    in_valid = 1'b0;
    step();
    check("rj_ok_done", {31'd0, done}, 32'd1);
    step();

    // Zero count
    kick(32'h20, 9'd0);
    check("z_done", {31'd0, done}, 32'd1);
    check("z_busy", {31'd0, busy}, 32'd0);
    check("z_we", {31'd0, mem_we}, 32'd0);
    step();
    check("z_done_once", {31'd0, done}, 32'd0);
    check("z_we2", {31'd0, mem_we}, 32'd0);

    // Start while busy is ignored
    kick(32'h40, 9'd1);
    kick(32'h80, 9'd3);
    check("sb_ready", {31'd0, in_ready}, 32'd1);
    check("sb_err", {31'd0, error}, 32'd0);
    in_valid = 1'b1; in_data = 32'h0102_0304;
    write_seq(32'h40, 32'h0102_0304);
    in_valid = 1'b0;
    step();
    check("sb_done", {31'd0, done}, 32'd1);
    step();

    // Reset during second byte of word 1
    in_valid = 1'b1; in_data = 32'hCAFE_F00D;
    kick(32'h100, 9'd2);
    write_seq(32'h100, 32'hCAFE_F00D);
    in_data = 32'h5566_7788;
    step();
    step();
    check("rm_b0_addr", mem_addr, 32'h104);
    step();
    check("rm_b1_addr", mem_addr, 32'h105);
    check("rm_b1_data", {24'd0, mem_wdata}, 32'h77);
    rst = 1'b1;
    #1;
    check("rm_we", {31'd0, mem_we}, 32'd0);
    check("rm_busy", {31'd0, busy}, 32'd0);
    check("rm_done", {31'd0, done}, 32'd0);
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (4) begin
      step();
      check("rm_no_done", {31'd0, done}, 32'd0);
      check("rm_no_we", {31'd0, mem_we}, 32'd0);
    end
    in_valid = 1'b1; in_data = 32'h0BAD_CAFE;
    kick(32'h200, 9'd1);
    write_seq(32'h200, 32'h0BAD_CAFE);
    in_valid = 1'b0;
    step();
    check("rm_new_done", {31'd0, done}, 32'd1);
    step();

`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    for (int pass = 0; pass < 2; pass++) begin
      expected_sum = (pass == 0) ? 32'h1 : 32'h2;
      in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
      kick(32'h300, 9'd2);
      check("cs_clr", checksum, 32'd0);
      write_seq(32'h300, 32'hFFFF_FFFF);
      in_data = 32'h0000_0002;
      step();
      write_seq(32'h304, 32'h0000_0002);
      in_valid = 1'b0;
      step();
      check("cs_done", {31'd0, done}, 32'd1);
      check("cs_sum", checksum, 32'h1);
      check("cs_err", {31'd0, error}, (pass == 0) ? 32'd0 : 32'd1);
      step();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
